// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants: register address width, datapath width and the XZR index.
package legv8_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 64;
  localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;
endpackage

// File: rtl/mux2_1.sv
// Shared mux library: 2:1 single-bit mux.
module mux2_1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  always_comb y = sel ? d1 : d0;
endmodule

// File: rtl/mux4_1.sv
// Shared mux library: 4:1 single-bit mux.
module mux4_1 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);
  always_comb y = d[sel];
endmodule

// File: rtl/mux8_1.sv
// Shared mux library: 8:1 single-bit mux.
module mux8_1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);
  always_comb y = d[sel];
endmodule

// File: rtl/reg_cell.sv
// One architectural register: DFF with write enable and synchronous active-low clear.
module reg_cell
  import legv8_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/register_file.sv
// LEGv8 register file: 31 stored registers plus XZR, two combinational read ports
// built from mux trees, one write port with write-through bypass.
module register_file
  import legv8_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ZERO_REG   = 32'(XZR)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(NUM_REGS)-1:0] read_reg1,
  input  logic [$clog2(NUM_REGS)-1:0] read_reg2,
  input  logic [$clog2(NUM_REGS)-1:0] write_reg,
  input  logic                        write_en,
  input  logic [DATA_WIDTH-1:0]       write_data,
  output logic [DATA_WIDTH-1:0]       read_data1,
  output logic [DATA_WIDTH-1:0]       read_data2
);
  localparam int unsigned ADDR_W    = $clog2(NUM_REGS);
  localparam int unsigned NUM_PORTS = 2;

  logic [NUM_REGS-1:0]   wr_dec;
  logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
  logic [NUM_REGS-1:0]   col    [DATA_WIDTH];
  logic [ADDR_W-1:0]     rd_addr[NUM_PORTS];
  logic [DATA_WIDTH-1:0] rd_data[NUM_PORTS];
  logic [NUM_PORTS-1:0]  byp;

  // One-hot write decode; XZR never gets an enable.
  always_comb begin
    wr_dec = '0;
    if (write_en) begin
      wr_dec[write_reg] = 1'b1;
    end
    wr_dec[ZERO_REG] = 1'b0;
  end

  always_comb assert (!wr_dec[ZERO_REG]);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == ZERO_REG) begin : g_xzr
      assign regs[r] = '0;
    end else begin : g_cell
      reg_cell #(.WIDTH(DATA_WIDTH)) u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (wr_dec[r]),
        .d       (write_data),
        .q       (regs[r])
      );
    end
  end

  // Bit-slice view: col[b] holds bit b of every register, one mux tree each.
  always_comb begin
    for (int b = 0; b < DATA_WIDTH; b++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        col[b][r] = regs[r][b];
      end
    end
  end

  assign rd_addr[0] = read_reg1;
  assign rd_addr[1] = read_reg2;

  // Bypass never fires on XZR or while reset holds the array cleared.
  always_comb begin
    byp = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      byp[p] = reset_n && write_en && (write_reg == rd_addr[p]) &&
               (rd_addr[p] != ADDR_W'(ZERO_REG));
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
      logic [3:0] grp;
      logic       tree;

      for (genvar g = 0; g < 4; g++) begin : g_grp
        mux8_1 u_m8 (
          .d   (col[b][g*8 +: 8]),
          .sel (rd_addr[p][2:0]),
          .y   (grp[g])
        );
      end

      mux4_1 u_m4 (
        .d   (grp),
        .sel (rd_addr[p][4:3]),
        .y   (tree)
      );

      mux2_1 u_m2 (
        .d0  (tree),
        .d1  (write_data[b]),
        .sel (byp[p]),
        .y   (rd_data[p][b])
      );
    end
  end

  assign read_data1 = rd_data[0];
  assign read_data2 = rd_data[1];
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: array model checked every cycle plus directed literals.
module tb_register_file;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic        write_en;
  logic [63:0] write_data;
  logic [63:0] read_data1, read_data2;

  int passed = 0;
  int total  = 0;

  logic [63:0] m [32];
  bit          model_valid = 1'b0;

  register_file dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_en   (write_en),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Architectural model: array state plus the read rules, no structure.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m[i] <= 64'h0;
      model_valid <= 1'b1;
    end else if (write_en && write_reg != 5'd31) begin
      m[write_reg] <= write_data;
    end
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (a == 5'd31) return 64'h0;
    if (reset_n && write_en && write_reg == a) return write_data;
    return m[a];
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_port1", read_data1, exp_rd(read_reg1));
      check("model_port2", read_data2, exp_rd(read_reg2));
    end
  end

  task automatic drive(input logic rn, input logic we, input logic [4:0] wr,
                       input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    #2;
    reset_n    = rn;
    write_en   = we;
    write_reg  = wr;
    write_data = wd;
    read_reg1  = r1;
    read_reg2  = r2;
  endtask

  task automatic lit(input string name, input logic [63:0] e1, input logic [63:0] e2);
    @(negedge clk);
    check({name, "_p1"}, read_data1, e1);
    check({name, "_p2"}, read_data2, e2);
  endtask

  initial begin
    reset_n = 1'b0; write_en = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    @(posedge clk);

    // Reset clear after preload
    for (int i = 0; i < 31; i++)
      drive(1'b1, 1'b1, 5'(i), 64'hA5A5_0000_0000_0000 | 64'(i), 5'd0, 5'd0);
    drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd4, 5'd30);
    lit("preload", 64'hA5A5_0000_0000_0004, 64'hA5A5_0000_0000_001E);
    drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd1);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i));
      lit("reset_clear", 64'h0, 64'h0);
    end

    // Write then read
    drive(1'b1, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd0);
    drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd5, 5'd6);
    lit("write_read", 64'h0123_4567_89AB_CDEF, 64'h0);

    // XZR write discarded
    drive(1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
    lit("xzr_same", 64'h0, 64'h0);
    drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd31, 5'd31);
    lit("xzr_next", 64'h0, 64'h0);

    // Bypass
    drive(1'b1, 1'b1, 5'd7, 64'h1, 5'd0, 5'd0);
    drive(1'b1, 1'b1, 5'd7, 64'h2, 5'd7, 5'd7);
    lit("bypass_same", 64'h2, 64'h2);
    drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd7, 5'd7);
    lit("bypass_next", 64'h2, 64'h2);

    // Reset beats write, no bypass during reset
    drive(1'b1, 1'b1, 5'd3, 64'h55, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 5'd3, 64'hDEAD, 5'd3, 5'd3);
    lit("reset_nobypass", 64'h55, 64'h55);
    drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd3, 5'd5);
    lit("reset_vs_write", 64'h0, 64'h0);

    // Back-to-back writes, last wins
    drive(1'b1, 1'b1, 5'd9, 64'hAA, 5'd0, 5'd0);
    drive(1'b1, 1'b1, 5'd9, 64'hBB, 5'd9, 5'd8);
    lit("b2b_bypass", 64'hBB, 64'h0);
    drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd9, 5'd9);
    lit("b2b_next", 64'hBB, 64'hBB);

    // Walk
    for (int i = 0; i < 31; i++)
      drive(1'b1, 1'b1, 5'(i), 64'(i), 5'd31, 5'd31);
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i));
      lit("walk", (i == 31) ? 64'h0 : 64'(i), (i == 0) ? 64'h0 : 64'(31 - i));
    end

    drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
